// File: rtl/bitstream_receiver.sv
// -----------------------------------------------------------------------------
// bitstream_receiver
//
// Receives framed serial words from an asynchronous source. bclk_in, nsync_in
// and data_in are synchronized into the clk domain. Bits are sampled on
// synchronized bit-clock rising edges, MSB first, while the active-low frame
// strobe is asserted. Completed words are presented on a valid/ready output
// register.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   enable       when low, no new frame may start (a running frame completes)
//   bclk_in      serial bit clock, data valid at its rising edge
//   nsync_in     active-low frame strobe
//   data_in      serial data, MSB first
//   data_o       last completed word
//   valid_o      data_o holds an unconsumed word
//   ready_i      consumer accepts data_o when valid_o && ready_i
//   overflow_o   sticky: a word was dropped because data_o was still full
//   frame_err_o  sticky: frame ended before DATA_WIDTH bits arrived
//   clr_i        synchronous clear of both sticky flags (a new set wins)
//   word_count_o completed-word counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module bitstream_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  bclk_in,
    input  logic                  nsync_in,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overflow_o,
    output logic                  frame_err_o,
    input  logic                  clr_i,
    output logic [15:0]           word_count_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] nsync_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   bclk_hist_r;
    logic                   nsync_hist_r;

    logic bclk_s;
    logic nsync_s;
    logic data_s;
    logic bclk_rise_s;
    logic nsync_fall_s;

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [CNT_W-1:0]      bit_cnt_next_s;
    logic                  word_done_s;
    logic                  frame_err_set_s;
    logic                  overflow_set_s;

    assign bclk_s       = bclk_sync_r[SYNC_STAGES-1];
    assign nsync_s      = nsync_sync_r[SYNC_STAGES-1];
    assign data_s       = data_sync_r[SYNC_STAGES-1];
    assign bclk_rise_s  = bclk_s & ~bclk_hist_r;
    assign nsync_fall_s = ~nsync_s & nsync_hist_r;

    // A word is lost only when the output is full and not being drained now.
    assign overflow_set_s = word_done_s & valid_o & ~ready_i;

    // Input synchronizers plus history flops for edge detection. nsync idles
    // high so reset never manufactures a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_r  <= '0;
            nsync_sync_r <= '1;
            data_sync_r  <= '0;
            bclk_hist_r  <= 1'b0;
            nsync_hist_r <= 1'b1;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[SYNC_STAGES-2:0], bclk_in};
            nsync_sync_r <= {nsync_sync_r[SYNC_STAGES-2:0], nsync_in};
            data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], data_in};
            bclk_hist_r  <= bclk_s;
            nsync_hist_r <= nsync_s;
        end
    end

    // FSM state, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
        end
    end

    // Next-state logic. Word completion is checked before the frame strobe so
    // a strobe release in the completing cycle is not counted as an error.
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        bit_cnt_next_s  = bit_cnt_r;
        word_done_s     = 1'b0;
        frame_err_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nsync_fall_s && enable) begin
                    state_next_s   = ST_SHIFT;
                    bit_cnt_next_s = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == CNT_W'(DATA_WIDTH)) begin
                    state_next_s = ST_WAIT_END;
                    word_done_s  = 1'b1;
                end else if (nsync_s) begin
                    state_next_s    = ST_IDLE;
                    frame_err_set_s = 1'b1;
                    shift_next_s    = '0;
                    bit_cnt_next_s  = '0;
                end else if (bclk_rise_s) begin
                    shift_next_s   = {shift_r[DATA_WIDTH-2:0], data_s};
                    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_WAIT_END: begin
                // Extra bit clocks are ignored until the strobe is released.
                if (nsync_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_END;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                shift_next_s   = '0;
                bit_cnt_next_s = '0;
            end
        endcase
    end

    // Output word register with valid/ready handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (word_done_s) begin
            if (!valid_o || ready_i) begin
                data_o  <= shift_r;
                valid_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Completed-word counter; dropped words count too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_o <= 16'd0;
        end else if (word_done_s) begin
            word_count_o <= word_count_o + 16'd1;
        end
    end

    // Sticky error flags; a set in the same cycle as clr_i takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (overflow_set_s) begin
                overflow_o <= 1'b1;
            end else if (clr_i) begin
                overflow_o <= 1'b0;
            end
            if (frame_err_set_s) begin
                frame_err_o <= 1'b1;
            end else if (clr_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_receiver.sv
module tb_bitstream_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bclk_in;
    logic        nsync_in;
    logic        data_in;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;
    logic        frame_err_o;
    logic        clr_i;
    logic [15:0] word_count_o;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [7:0]  exp_q[$];
    int          exp_count = 0;

    always #5 clk = ~clk;

    bitstream_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bclk_in      (bclk_in),
        .nsync_in     (nsync_in),
        .data_in      (data_in),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overflow_o   (overflow_o),
        .frame_err_o  (frame_err_o),
        .clr_i        (clr_i),
        .word_count_o (word_count_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", exp_q.size(), 1);
            end else begin
                check_val("sb_data", data_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 0 plain, 1 latency check, 2 ready pulse at word-done,
    // 3 drop enable after first bit, 4 leave nsync low at the end.
    task automatic send_frame(input logic [7:0] w, input int nbits, input int mode);
        nsync_in = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nbits; i++) begin
            data_in = w[7-i];
            bclk_in = 1'b0;
            repeat (4) tick();
            bclk_in = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (i == nbits - 1 && mode == 1) begin
                    if (k == 3) check_val("lat_early", valid_o, 0);
                    if (k == 4) check_val("lat_valid", valid_o, 1);
                end
                if (i == nbits - 1 && mode == 2) begin
                    if (k == 3) ready_i = 1'b1;
                    if (k == 4) ready_i = 1'b0;
                end
            end
            if (i == 0 && mode == 3) enable = 1'b0;
        end
        bclk_in = 1'b0;
        repeat (4) tick();
        if (mode != 4) begin
            nsync_in = 1'b1;
            repeat (6) tick();
        end
        enable = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        bclk_in  = 1'b0;
        nsync_in = 1'b1;
        data_in  = 1'b0;
        ready_i  = 1'b1;
        clr_i    = 1'b0;
        repeat (3) tick();
        check_val("rst_data", data_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_ovf", overflow_o, 0);
        check_val("rst_ferr", frame_err_o, 0);
        check_val("rst_count", word_count_o, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic frame with latency check.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1);
        exp_count++;
        check_val("a5_count", word_count_o, exp_count);

        // Overflow: second word dropped while the first is unconsumed.
        ready_i = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 8, 0);
        send_frame(8'hC3, 8, 0);
        exp_count += 2;
        check_val("ovf_valid", valid_o, 1);
        check_val("ovf_data", data_o, 8'h3C);
        check_val("ovf_flag", overflow_o, 1);
        check_val("ovf_count", word_count_o, exp_count);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_val("ovf_clr", overflow_o, 0);
        check_val("ovf_hold", data_o, 8'h3C);
        ready_i = 1'b1;
        repeat (3) tick();

        // Short frame raises frame error; next full frame is fine.
        send_frame(8'hF0, 5, 0);
        check_val("ferr_flag", frame_err_o, 1);
        check_val("ferr_valid", valid_o, 0);
        check_val("ferr_count", word_count_o, exp_count);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 8, 0);
        exp_count++;
        check_val("ferr_sticky", frame_err_o, 1);
        check_val("x81_count", word_count_o, exp_count);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_val("ferr_clr", frame_err_o, 0);

        // Reset mid-frame discards everything without flags.
        send_frame(8'h5A, 3, 4);
        rst      = 1'b1;
        nsync_in = 1'b1;
        repeat (2) tick();
        check_val("mrst_data", data_o, 0);
        check_val("mrst_valid", valid_o, 0);
        check_val("mrst_ovf", overflow_o, 0);
        check_val("mrst_ferr", frame_err_o, 0);
        check_val("mrst_count", word_count_o, 0);
        exp_count = 0;
        rst = 1'b0;
        repeat (3) tick();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 8, 0);
        exp_count++;
        check_val("x7e_ferr", frame_err_o, 0);
        check_val("x7e_count", word_count_o, exp_count);

        // Enable low at frame start blocks it; dropping it mid-frame does not.
        enable = 1'b0;
        send_frame(8'h12, 8, 0);
        check_val("en_count", word_count_o, exp_count);
        check_val("en_valid", valid_o, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 8, 3);
        exp_count++;
        check_val("x55_count", word_count_o, exp_count);

        // Counter wrap.
        @(negedge clk);
        force dut.word_count_o = 16'hFFFF;
        tick();
        release dut.word_count_o;
        exp_count = 16'hFFFF;
        tick();
        check_val("wrap_pre", word_count_o, exp_count);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 8, 0);
        exp_count = (exp_count + 1) & 16'hFFFF;
        check_val("wrap_count", word_count_o, exp_count);

        // Word-done coincident with a handshake on the previous word.
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 8, 0);
        exp_count++;
        exp_q.push_back(8'h22);
        send_frame(8'h22, 8, 2);
        exp_count++;
        check_val("conc_ovf", overflow_o, 0);
        check_val("conc_data", data_o, 8'h22);
        check_val("conc_valid", valid_o, 1);
        check_val("conc_count", word_count_o, exp_count);
        ready_i = 1'b1;
        repeat (5) tick();
        check_val("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
